ecc_lockstep_mon: RTL and testbench



---
 rtl/ecc_lockstep_mon.sv | 249 ++++++++++++++++++++++++
 tb/tb_ecc_lockstep_mon.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_lockstep_mon.sv
// ecc_lockstep_mon
// Lockstep SECDED decode monitor for the FIFO ECC read path. Two copies of
// the SECDED decoder see the same read beat, and their syndrome results are
// compared every cycle. A disagreement is an ECC logic fault. When that
// happens the raw read data is forwarded, because the copy-0 correction can
// no longer be trusted. All outputs are registered, so latency is one cycle.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_vld              beat valid
//   data_in, parity_in  raw read data and its stored check bits
//   bypass              decoder bypass, applied to both copies
//   detc_en             lockstep compare enable
//   clr                 clears sticky flags and counters
//   selftest_req        starts the comparator self-test
//   out_vld, data_out   registered beat valid and (corrected or raw) data
//   sbit_err, dbit_err, ecc_fault           per-beat flags, qualified by out_vld
//   sbit_sticky, dbit_sticky, fault_sticky  sticky flags
//   sbit_cnt, dbit_cnt, fault_cnt           saturating event counters
//   selftest_busy, selftest_done, selftest_pass  self-test status
//
// Check-bit code: extended Hamming. Data bits occupy codeword positions
// 3,5,6,7,9,... in order, skipping the powers of two. Check bit i covers the
// positions that have bit i set. The top check bit is overall parity over
// the data and the lower check bits.
module ecc_lockstep_mon #(
  parameter int DATA_WIDTH   = 83,
  parameter int PARITY_WIDTH = 8,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_vld,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic [PARITY_WIDTH-1:0] parity_in,
  input  logic                    bypass,
  input  logic                    detc_en,
  input  logic                    clr,
  input  logic                    selftest_req,
  output logic                    out_vld,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    sbit_err,
  output logic                    dbit_err,
  output logic                    ecc_fault,
  output logic                    sbit_sticky,
  output logic                    dbit_sticky,
  output logic                    fault_sticky,
  output logic [CNT_WIDTH-1:0]    sbit_cnt,
  output logic [CNT_WIDTH-1:0]    dbit_cnt,
  output logic [CNT_WIDTH-1:0]    fault_cnt,
  output logic                    selftest_busy,
  output logic                    selftest_done,
  output logic                    selftest_pass
);

  localparam int HAM_W = PARITY_WIDTH - 1;

  typedef struct packed {
    logic                  sbit;
    logic                  dbit;
    logic [DATA_WIDTH-1:0] mask;
  } dec_t;

  typedef enum logic [1:0] {ST_IDLE, ST_INJ, ST_CHK, ST_DONE} st_e;

  // The generic SECDED decoder core. It is called once per lockstep copy.
  function automatic dec_t secded_dec(input logic [DATA_WIDTH-1:0]   d,
                                      input logic [PARITY_WIDTH-1:0] p,
                                      input logic                    byp);
    dec_t            r;
    logic [HAM_W-1:0] syn;
    logic            ovr;
    logic            hit;
    logic            chk_pos;
    logic [31:0]     pos;
    syn = p[HAM_W-1:0];
    ovr = (^d) ^ (^p);
    pos = 32'd3;
    for (int j = 0; j < DATA_WIDTH; j++) begin
      if ((pos & (pos - 32'd1)) == 32'd0) pos = pos + 32'd1;
      for (int i = 0; i < HAM_W; i++) begin
        if (pos[i]) syn[i] = syn[i] ^ d[j];
      end
      pos = pos + 32'd1;
    end
    r.mask = '0;
    pos = 32'd3;
    for (int j = 0; j < DATA_WIDTH; j++) begin
      if ((pos & (pos - 32'd1)) == 32'd0) pos = pos + 32'd1;
      r.mask[j] = ovr & (syn == pos[HAM_W-1:0]);
      pos = pos + 32'd1;
    end
    hit = |r.mask;
    // A zero or power-of-two syndrome with odd parity means the flipped
    // bit is a check bit, so there is no data to correct.
    chk_pos = ((syn & (syn - 1'b1)) == '0);
    r.sbit = ovr & (hit | chk_pos);
    r.dbit = (~ovr & (|syn)) | (ovr & ~hit & ~chk_pos);
    if (byp) begin
      r = '0;
    end
    return r;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] cnt_next(input logic [CNT_WIDTH-1:0] c,
                                                    input logic                 ev,
                                                    input logic                 clr_i);
    logic [CNT_WIDTH-1:0] one;
    one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    if (clr_i) return ev ? one : '0;
    if (ev && (c != '1)) return c + one;
    return c;
  endfunction

  function automatic logic sticky_next(input logic s, input logic ev, input logic clr_i);
    return clr_i ? ev : (s | ev);
  endfunction

  dec_t                  dec0, dec1;
  logic [DATA_WIDTH-1:0] mask1;
  logic [DATA_WIDTH-1:0] mask1_cmp;
  logic                  inj;
  logic                  match;
  logic                  fault_raw;

  st_e                   state_q, state_d;
  logic                  st_mis_q, st_mis_d;
  logic                  st_ok_q, st_ok_d;
  logic                  pass_q, pass_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  out_vld_q, out_vld_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  sbit_q, sbit_d, dbit_q, dbit_d, fault_q, fault_d;
  logic                  sbit_st_q, sbit_st_d, dbit_st_q, dbit_st_d, fault_st_q, fault_st_d;
  logic [CNT_WIDTH-1:0]  sbit_cnt_q, sbit_cnt_d, dbit_cnt_q, dbit_cnt_d, fault_cnt_q, fault_cnt_d;

  assign dec0  = secded_dec(data_in, parity_in, bypass);
  assign dec1  = secded_dec(data_in, parity_in, bypass);
  assign mask1 = dec1.mask;

  // While in INJ, bit 0 of copy 1's mask is inverted. This proves that the
  // comparator can actually see a mismatch.
  assign inj       = (state_q == ST_INJ);
  assign mask1_cmp = mask1 ^ {{(DATA_WIDTH-1){1'b0}}, inj};
  assign match     = ~|({dec0.sbit, dec0.dbit, dec0.mask} ^ {dec1.sbit, dec1.dbit, mask1_cmp});
  assign fault_raw = ~match & detc_en & ~inj;

  always_comb begin
    out_vld_d   = in_vld;
    data_out_d  = data_out_q;
    if (in_vld) begin
      data_out_d = fault_raw ? data_in : (data_in ^ dec0.mask);
    end
    sbit_d      = in_vld & dec0.sbit;
    dbit_d      = in_vld & dec0.dbit;
    fault_d     = in_vld & fault_raw;
    sbit_st_d   = sticky_next(sbit_st_q, sbit_d, clr);
    dbit_st_d   = sticky_next(dbit_st_q, dbit_d, clr);
    fault_st_d  = sticky_next(fault_st_q, fault_d, clr);
    sbit_cnt_d  = cnt_next(sbit_cnt_q, sbit_d, clr);
    dbit_cnt_d  = cnt_next(dbit_cnt_q, dbit_d, clr);
    fault_cnt_d = cnt_next(fault_cnt_q, fault_d, clr);
  end

  always_comb begin
    state_d  = state_q;
    st_mis_d = st_mis_q;
    st_ok_d  = st_ok_q;
    pass_d   = pass_q;
    case (state_q)
      ST_IDLE: if (selftest_req) state_d = ST_INJ;
      ST_INJ: begin
        st_mis_d = ~match;
        state_d  = ST_CHK;
      end
      ST_CHK: begin
        st_ok_d = match;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        pass_d  = st_mis_q & st_ok_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Busy is decoded from the next state so that it is high exactly while
    // the FSM sits in INJ or CHK. Done and pass register one cycle after DONE.
    busy_d = (state_d == ST_INJ) || (state_d == ST_CHK);
    done_d = (state_q == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      st_mis_q    <= 1'b0;
      st_ok_q     <= 1'b0;
      pass_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_vld_q   <= 1'b0;
      data_out_q  <= '0;
      sbit_q      <= 1'b0;
      dbit_q      <= 1'b0;
      fault_q     <= 1'b0;
      sbit_st_q   <= 1'b0;
      dbit_st_q   <= 1'b0;
      fault_st_q  <= 1'b0;
      sbit_cnt_q  <= '0;
      dbit_cnt_q  <= '0;
      fault_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      st_mis_q    <= st_mis_d;
      st_ok_q     <= st_ok_d;
      pass_q      <= pass_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      out_vld_q   <= out_vld_d;
      data_out_q  <= data_out_d;
      sbit_q      <= sbit_d;
      dbit_q      <= dbit_d;
      fault_q     <= fault_d;
      sbit_st_q   <= sbit_st_d;
      dbit_st_q   <= dbit_st_d;
      fault_st_q  <= fault_st_d;
      sbit_cnt_q  <= sbit_cnt_d;
      dbit_cnt_q  <= dbit_cnt_d;
      fault_cnt_q <= fault_cnt_d;
    end
  end

  assign out_vld       = out_vld_q;
  assign data_out      = data_out_q;
  assign sbit_err      = sbit_q;
  assign dbit_err      = dbit_q;
  assign ecc_fault     = fault_q;
  assign sbit_sticky   = sbit_st_q;
  assign dbit_sticky   = dbit_st_q;
  assign fault_sticky  = fault_st_q;
  assign sbit_cnt      = sbit_cnt_q;
  assign dbit_cnt      = dbit_cnt_q;
  assign fault_cnt     = fault_cnt_q;
  assign selftest_busy = busy_q;
  assign selftest_done = done_q;
  assign selftest_pass = pass_q;

endmodule

// File: tb/tb_ecc_lockstep_mon.sv
// Testbench for ecc_lockstep_mon. Expected beat results are queued when a
// beat is driven and then compared when out_vld returns. Status outputs are
// compared directly, one cycle after the edge they depend on.
module tb_ecc_lockstep_mon;
  localparam int DW = 83;
  localparam int PW = 8;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_vld = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [PW-1:0] parity_in = '0;
  logic          bypass = 1'b0;
  logic          detc_en = 1'b0;
  logic          clr = 1'b0;
  logic          selftest_req = 1'b0;
  logic          out_vld;
  logic [DW-1:0] data_out;
  logic          sbit_err, dbit_err, ecc_fault;
  logic          sbit_sticky, dbit_sticky, fault_sticky;
  logic [CW-1:0] sbit_cnt, dbit_cnt, fault_cnt;
  logic          selftest_busy, selftest_done, selftest_pass;

  ecc_lockstep_mon #(.DATA_WIDTH(DW), .PARITY_WIDTH(PW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .data_in(data_in), .parity_in(parity_in),
    .bypass(bypass), .detc_en(detc_en), .clr(clr), .selftest_req(selftest_req),
    .out_vld(out_vld), .data_out(data_out), .sbit_err(sbit_err), .dbit_err(dbit_err),
    .ecc_fault(ecc_fault), .sbit_sticky(sbit_sticky), .dbit_sticky(dbit_sticky),
    .fault_sticky(fault_sticky), .sbit_cnt(sbit_cnt), .dbit_cnt(dbit_cnt),
    .fault_cnt(fault_cnt), .selftest_busy(selftest_busy), .selftest_done(selftest_done),
    .selftest_pass(selftest_pass)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          sb;
    logic          db;
    logic          flt;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] enc(input logic [DW-1:0] d);
    logic [PW-1:0] p;
    int            pos;
    p   = '0;
    pos = 2;
    for (int j = 0; j < DW; j++) begin
      pos++;
      if ((pos & (pos - 1)) == 0) pos++;
      for (int i = 0; i < PW - 1; i++) begin
        if (pos[i]) p[i] = p[i] ^ d[j];
      end
    end
    p[PW-1] = ^{d, p[PW-2:0]};
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Flip codes: -1 means no flip, 0..DW-1 is a data bit, 100+k is check bit k.
  task automatic beat(input logic [DW-1:0] orig, input int f0, input int f1,
                      input logic mism, input logic inj);
    logic [DW-1:0] raw;
    logic [PW-1:0] par;
    int            n;
    int            f[2];
    exp_t          e;
    raw  = orig;
    par  = enc(orig);
    n    = 0;
    f[0] = f0;
    f[1] = f1;
    for (int k = 0; k < 2; k++) begin
      if (f[k] >= 100) begin
        par[f[k]-100] = ~par[f[k]-100];
        n++;
      end else if (f[k] >= 0) begin
        raw[f[k]] = ~raw[f[k]];
        n++;
      end
    end
    e.flt  = mism & detc_en & ~inj;
    e.sb   = (n == 1) & ~bypass;
    e.db   = (n == 2) & ~bypass;
    e.data = (e.flt || bypass || n != 1) ? raw : orig;
    q.push_back(e);
    in_vld    = 1'b1;
    data_in   = raw;
    parity_in = par;
    step();
    in_vld = 1'b0;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (out_vld) begin
        if (q.size() == 0) begin
          chk("unexpected_out_vld", 1'b1, 1'b0);
        end else begin
          e = q.pop_front();
          chk("data_out", data_out, e.data);
          chk("sbit_err", sbit_err, e.sb);
          chk("dbit_err", dbit_err, e.db);
          chk("ecc_fault", ecc_fault, e.flt);
        end
      end else if (sbit_err || dbit_err || ecc_fault) begin
        chk("flags_without_vld", {sbit_err, dbit_err, ecc_fault}, 3'b000);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d0, dr;
    logic [95:0]   r96;
    logic [DW-1:0] fmask;
    int            kind, b0, b1, ndone;

    d0 = 83'h1234_5678_9ABC_DEF0_1234;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_out_vld", out_vld, 1'b0);
    chk("rst_data_out", data_out, '0);
    chk("rst_sticky", {sbit_sticky, dbit_sticky, fault_sticky}, 3'b000);
    chk("rst_cnts", {sbit_cnt, dbit_cnt, fault_cnt}, '0);
    chk("rst_selftest", {selftest_busy, selftest_done, selftest_pass}, 3'b000);

    detc_en = 1'b1;
    beat(d0, -1, -1, 1'b0, 1'b0);
    chk("clean_cnt", {sbit_cnt, dbit_cnt, fault_cnt}, '0);
    chk("clean_sticky", {sbit_sticky, dbit_sticky, fault_sticky}, 3'b000);
    step();
    chk("hold_data", data_out, d0);

    beat(d0, 5, -1, 1'b0, 1'b0);
    chk("sbit_sticky", sbit_sticky, 1'b1);
    chk("sbit_cnt1", sbit_cnt, 2'd1);
    beat(d0, 5, 9, 1'b0, 1'b0);
    chk("dbit_sticky", dbit_sticky, 1'b1);
    chk("dbit_cnt1", dbit_cnt, 2'd1);
    beat(d0, 103, -1, 1'b0, 1'b0);
    chk("sbit_cnt_parity", sbit_cnt, 2'd2);
    beat(d0, 82, -1, 1'b0, 1'b0);
    beat(d0, 0, 82, 1'b0, 1'b0);

    for (int t = 0; t < 8; t++) begin
      r96  = {$urandom(), $urandom(), $urandom()};
      dr   = r96[DW-1:0];
      kind = $urandom_range(0, 2);
      b0   = $urandom_range(0, DW - 1);
      b1   = (b0 + 1 + $urandom_range(0, DW - 2)) % DW;
      if (kind == 0) beat(dr, -1, -1, 1'b0, 1'b0);
      else if (kind == 1) beat(dr, b0, -1, 1'b0, 1'b0);
      else beat(dr, b0, b1, 1'b0, 1'b0);
    end
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_cnts", {sbit_cnt, dbit_cnt, fault_cnt}, '0);
    chk("clr_sticky", {sbit_sticky, dbit_sticky, fault_sticky}, 3'b000);

    // Copy 1 is made to claim a different correction than copy 0.
    fmask = '0;
    fmask[5] = 1'b1;
    fmask[7] = 1'b1;
    force dut.mask1 = fmask;
    beat(d0, 5, -1, 1'b1, 1'b0);
    chk("fault_cnt1", fault_cnt, 2'd1);
    chk("fault_sticky", fault_sticky, 1'b1);
    detc_en = 1'b0;
    beat(d0, 5, -1, 1'b1, 1'b0);
    chk("fault_cnt_dis", fault_cnt, 2'd1);
    release dut.mask1;
    detc_en = 1'b1;

    bypass = 1'b1;
    beat(d0, 5, -1, 1'b0, 1'b0);
    bypass = 1'b0;

    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int t = 0; t < 5; t++) beat(d0, 3 + t, -1, 1'b0, 1'b0);
    chk("sbit_cnt_sat", sbit_cnt, 2'd3);
    clr = 1'b1;
    beat(d0, 11, -1, 1'b0, 1'b0);
    clr = 1'b0;
    chk("clr_event_cnt", sbit_cnt, 2'd1);
    chk("clr_event_sticky", sbit_sticky, 1'b1);
    step();

    // Self-test on clean data
    selftest_req = 1'b1;
    step();
    selftest_req = 1'b0;
    chk("st_busy_inj", selftest_busy, 1'b1);
    beat(d0, -1, -1, 1'b0, 1'b1);
    chk("st_busy_chk", selftest_busy, 1'b1);
    chk("st_done_early", selftest_done, 1'b0);
    beat(d0, -1, -1, 1'b0, 1'b0);
    chk("st_busy_done", selftest_busy, 1'b0);
    chk("st_done_n2", selftest_done, 1'b0);
    step();
    chk("st_done_pulse", selftest_done, 1'b1);
    chk("st_pass", selftest_pass, 1'b1);
    step();
    chk("st_done_clear", selftest_done, 1'b0);
    chk("st_pass_held", selftest_pass, 1'b1);
    chk("st_no_fault", fault_cnt, 2'd0);

    // Self-test with copy 1 disagreeing through CHK
    selftest_req = 1'b1;
    step();
    selftest_req = 1'b0;
    fmask = '0;
    fmask[3] = 1'b1;
    force dut.mask1 = fmask;
    beat(d0, -1, -1, 1'b1, 1'b1);
    beat(d0, -1, -1, 1'b1, 1'b0);
    release dut.mask1;
    chk("stf_fault_cnt", fault_cnt, 2'd1);
    step();
    chk("stf_done", selftest_done, 1'b1);
    chk("stf_pass", selftest_pass, 1'b0);
    step();

    // Self-test interrupted by reset
    selftest_req = 1'b1;
    step();
    selftest_req = 1'b0;
    chk("str_busy_inj", selftest_busy, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("str_busy_rst", selftest_busy, 1'b0);
    ndone = 0;
    for (int t = 0; t < 4; t++) begin
      step();
      if (selftest_done || selftest_busy) ndone++;
    end
    chk("str_no_done", ndone, 0);

    // A held request restarts the test every four cycles.
    ndone = 0;
    selftest_req = 1'b1;
    for (int t = 0; t < 8; t++) begin
      step();
      if (selftest_done) ndone++;
    end
    selftest_req = 1'b0;
    chk("held_req_dones", ndone, 2);
    chk("held_req_pass", selftest_pass, 1'b1);
    step();
    step();

    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
